// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter and any future pixel-path blocks.
//   FB_WIDTH / FB_HEIGHT : default framebuffer geometry in pixels
//   cpu_state_e          : CPU request port FSM states
//   rgb888_t             : expanded 8-bit-per-channel pixel
//   rgb332_expand        : RGB332 byte -> 8-bit r/g/b by bit replication
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 240;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } cpu_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicating the top bits keeps full-scale codes at 8'hFF and zero at 8'h00.
    function automatic rgb888_t rgb332_expand(input logic [7:0] p);
        rgb888_t c;
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {p[1:0], p[1:0], p[1:0], p[1:0]};
        return c;
    endfunction

endpackage

// File: rtl/fb_cpu_port.sv
// CPU side of the framebuffer arbiter: request FSM, read-data capture and ack pulse.
//   clock25mhz    : system clock
//   resetn        : synchronous active-low reset
//   grant_allowed : high when the video side leaves the RAM port free this cycle
//   cpu_req/we/addr : held stable by the requester until cpu_ack
//   mem_rdata     : RAM read data (one cycle after the granted address)
//   cpu_grant     : this cycle the RAM port carries the CPU access
//   cpu_mem_we    : write enable to use while granted (dropped for out-of-range addresses)
//   cpu_ack       : one-cycle completion pulse
//   cpu_rdata     : last read result, held until the next read completes
module fb_cpu_port
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH  = FB_WIDTH,
    parameter int unsigned HEIGHT = FB_HEIGHT,
    parameter int unsigned ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clock25mhz,
    input  logic              resetn,
    input  logic              grant_allowed,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_grant,
    output logic              cpu_mem_we,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata
);

    localparam logic [ADDR_W-1:0] NumPix = ADDR_W'(WIDTH * HEIGHT);

    cpu_state_e state_q;
    logic       op_read_q;
    logic       op_ok_q;
    logic       ack_q;
    logic [7:0] rdata_q;
    logic       addr_ok;

    assign addr_ok    = (cpu_addr < NumPix);
    assign cpu_grant  = resetn && (state_q == IDLE) && cpu_req && grant_allowed;
    assign cpu_mem_we = cpu_we && addr_ok;
    assign cpu_ack    = ack_q;
    assign cpu_rdata  = rdata_q;

    always_ff @(posedge clock25mhz) begin
        if (!resetn) begin
            state_q   <= IDLE;
            op_read_q <= 1'b0;
            op_ok_q   <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (cpu_grant) begin
                        op_read_q <= !cpu_we;
                        op_ok_q   <= addr_ok;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    // RAM data for the granted address is on mem_rdata now.
                    if (op_read_q) begin
                        rdata_q <= op_ok_q ? mem_rdata : 8'h00;
                    end
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    // cpu_req is not looked at here, so a requester dropping req
                    // the cycle after ack cannot re-trigger the same access.
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Shares one single-port synchronous framebuffer RAM between video scanout and a CPU port.
// Scanout always wins; the CPU gets every cycle scanout does not fetch. Pixels are RGB332,
// expanded to 8-bit r/g/b with a fixed 2-cycle latency from vid_x/vid_y.
//   clock25mhz           : pixel/system clock
//   resetn               : synchronous active-low reset
//   vid_x, vid_y         : scanout coordinate from the hdmi block
//   vid_r, vid_g, vid_b  : expanded pixel, zero for out-of-range coordinates
//   cpu_req/we/addr/wdata: CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata   : completion pulse and read data
//   mem_addr/we/wdata    : RAM port, mem_rdata arrives one cycle after mem_addr
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH  = FB_WIDTH,
    parameter int unsigned HEIGHT = FB_HEIGHT,
    parameter int unsigned ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clock25mhz,
    input  logic              resetn,
    input  logic [11:0]       vid_x,
    input  logic [11:0]       vid_y,
    output logic [7:0]        vid_r,
    output logic [7:0]        vid_g,
    output logic [7:0]        vid_b,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    logic [ADDR_W-1:0] vaddr;
    logic              in_range;
    logic              vid_fetch;
    logic [ADDR_W-1:0] last_vid_addr_q;
    logic              fetch_d1_q;
    logic              valid1_q;
    logic              valid2_q;
    logic [7:0]        pix_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              cpu_grant;
    logic              cpu_mem_we;
    rgb888_t           pix_rgb;

    assign vaddr    = ADDR_W'(vid_y) * ADDR_W'(WIDTH) + ADDR_W'(vid_x);
    assign in_range = (vid_x < 12'(WIDTH)) && (vid_y < 12'(HEIGHT));
    // Same address as last time means pix_q already holds it; no refetch.
    assign vid_fetch = resetn && in_range && (vaddr != last_vid_addr_q);

    fb_cpu_port #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W)
    ) u_cpu_port (
        .clock25mhz   (clock25mhz),
        .resetn       (resetn),
        .grant_allowed(!vid_fetch),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .mem_rdata    (mem_rdata),
        .cpu_grant    (cpu_grant),
        .cpu_mem_we   (cpu_mem_we),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata)
    );

    // RAM port mux; address and write data hold their last value when the port is idle.
    always_comb begin
        mem_addr  = mem_addr_q;
        mem_we    = 1'b0;
        mem_wdata = mem_wdata_q;
        if (vid_fetch) begin
            mem_addr = vaddr;
        end else if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_mem_we;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clock25mhz) begin
        if (!resetn) begin
            // All-ones is never a valid pixel address, so the first coordinate fetches.
            last_vid_addr_q <= '1;
            fetch_d1_q      <= 1'b0;
            valid1_q        <= 1'b0;
            valid2_q        <= 1'b0;
            pix_q           <= 8'h00;
            mem_addr_q      <= '0;
            mem_wdata_q     <= 8'h00;
        end else begin
            if (vid_fetch) begin
                last_vid_addr_q <= vaddr;
            end
            fetch_d1_q <= vid_fetch;
            // Only capture when the previous cycle was a video fetch; otherwise
            // mem_rdata belongs to a CPU access.
            if (fetch_d1_q) begin
                pix_q <= mem_rdata;
            end
            valid1_q    <= in_range;
            valid2_q    <= valid1_q;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
        end
    end

    always_comb begin
        pix_rgb = '0;
        if (valid2_q) begin
            pix_rgb = rgb332_expand(pix_q);
        end
    end

    assign vid_r = pix_rgb.r;
    assign vid_g = pix_rgb.g;
    assign vid_b = pix_rgb.b;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter: directed stimulus pushes expectations into queues,
// a negedge monitor pops and compares video pixels, RAM-port cycles and CPU acks.
module tb_fb_arbiter;

    localparam int W    = 320;
    localparam int H    = 240;
    localparam int NPIX = W * H;

    logic        clock25mhz = 1'b0;
    logic        resetn;
    logic [11:0] vid_x, vid_y;
    logic [7:0]  vid_r, vid_g, vid_b;
    logic        cpu_req, cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clock25mhz = ~clock25mhz;

    fb_arbiter #(
        .WIDTH (W),
        .HEIGHT(H)
    ) dut (
        .clock25mhz(clock25mhz),
        .resetn    (resetn),
        .vid_x     (vid_x),
        .vid_y     (vid_y),
        .vid_r     (vid_r),
        .vid_g     (vid_g),
        .vid_b     (vid_b),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        string       name;
    } vid_exp_t;

    typedef struct {
        int          cyc;
        logic [16:0] addr;
        bit          chk_addr;
        logic        we;
        string       name;
    } port_exp_t;

    typedef struct {
        int          issue;
        int          minl;
        int          maxl;
        bit          chk;
        logic [7:0]  rdata;
        string       name;
    } cpu_exp_t;

    vid_exp_t   vq[$];
    port_exp_t  pq[$];
    cpu_exp_t   cq[$];
    logic [7:0] sh [int];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    bit done   = 1'b0;

    always @(posedge clock25mhz) cyc <= cyc + 1;

    // Initial framebuffer content; 323 carries the hand-picked test pixel.
    function automatic logic [7:0] pat(input int a);
        if (a == 323) return 8'hE3;
        return 8'(a * 37 + a / 256);
    endfunction

    function automatic logic [7:0] exp_pix(input int a);
        if (sh.exists(a)) return sh[a];
        return pat(a);
    endfunction

    function automatic logic [23:0] tb_expand(input logic [7:0] p);
        logic [2:0] r3, g3;
        logic [1:0] b2;
        r3 = p[7:5];
        g3 = p[4:2];
        b2 = p[1:0];
        return {r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};
    endfunction

    // RAM model: 1-cycle registered read, unwritten locations read the initial pattern.
    logic [7:0] ram [0:131071];
    bit         wr  [0:131071];
    always @(posedge clock25mhz) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr[mem_addr]  <= 1'b1;
        end
        mem_rdata <= wr[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
    end

    task automatic tick();
        @(posedge clock25mhz);
        #1;
    endtask

    task automatic exp_vid(input int c, input logic [23:0] rgb, input string nm);
        vid_exp_t e;
        e.cyc = c; e.rgb = rgb; e.name = nm;
        vq.push_back(e);
    endtask

    task automatic exp_port(input int c, input logic [16:0] a, input bit ca, input logic we,
                            input string nm);
        port_exp_t e;
        e.cyc = c; e.addr = a; e.chk_addr = ca; e.we = we; e.name = nm;
        pq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    task automatic cpu_txn(input logic we, input logic [16:0] a, input logic [7:0] wd,
                           input bit ck, input logic [7:0] erd, input int minl, input int maxl,
                           input string nm);
        cpu_exp_t e;
        bit       got;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        e.issue = cyc; e.minl = minl; e.maxl = maxl; e.chk = ck; e.rdata = erd; e.name = nm;
        cq.push_back(e);
        if (we && int'(a) < NPIX) sh[int'(a)] = wd;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock25mhz);
            if (cpu_ack === 1'b1) got = 1'b1;
            else tick();
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no ack within 20 cycles, got none, want ack", nm);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    // Video model: output in cycle k+2 is the pixel of the cycle-k coordinate when it was in
    // range and reset was high in cycles k and k+1, else zero.
    initial begin
        bit          p_in, p_rst;
        int          p_addr;
        bit          c_in;
        int          c_addr;
        p_in = 1'b0; p_rst = 1'b0; p_addr = 0;
        @(posedge clock25mhz);
        forever begin
            #2;
            c_in   = (int'(vid_x) < W) && (int'(vid_y) < H);
            c_addr = int'(vid_y) * W + int'(vid_x);
            exp_vid(cyc + 1, (p_in && p_rst && resetn) ? tb_expand(exp_pix(p_addr)) : 24'h0,
                    "vid_model");
            p_in = c_in; p_rst = resetn; p_addr = c_addr;
            @(posedge clock25mhz);
        end
    end

    // Monitor: compare everything due this cycle, flag anything overdue.
    always @(negedge clock25mhz) begin
        if (mon_en) begin
            for (int i = vq.size() - 1; i >= 0; i--) begin
                if (vq[i].cyc <= cyc) begin
                    n_cmp++;
                    if (vq[i].cyc < cyc || {vid_r, vid_g, vid_b} !== vq[i].rgb) begin
                        n_fail++;
                        $display("FAIL %s cyc %0d: rgb got %h, want %h", vq[i].name, cyc,
                                 {vid_r, vid_g, vid_b}, vq[i].rgb);
                    end
                    vq.delete(i);
                end
            end
            for (int i = pq.size() - 1; i >= 0; i--) begin
                if (pq[i].cyc <= cyc) begin
                    n_cmp++;
                    if (pq[i].cyc < cyc || mem_we !== pq[i].we ||
                        (pq[i].chk_addr && mem_addr !== pq[i].addr)) begin
                        n_fail++;
                        $display("FAIL %s cyc %0d: mem_addr/we got %0d/%b, want %0d/%b",
                                 pq[i].name, cyc, mem_addr, mem_we, pq[i].addr, pq[i].we);
                    end
                    pq.delete(i);
                end
            end
            if (cpu_ack !== 1'b0) begin
                n_cmp++;
                if (cq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack cyc %0d: ack got %b, want 0", cyc, cpu_ack);
                end else begin
                    cpu_exp_t e;
                    int       lat;
                    e   = cq.pop_front();
                    lat = cyc - e.issue;
                    if (lat < e.minl || lat > e.maxl) begin
                        n_fail++;
                        $display("FAIL %s latency: got %0d, want %0d..%0d", e.name, lat,
                                 e.minl, e.maxl);
                    end
                    if (e.chk) begin
                        n_cmp++;
                        if (cpu_rdata !== e.rdata) begin
                            n_fail++;
                            $display("FAIL %s rdata: got %h, want %h", e.name, cpu_rdata,
                                     e.rdata);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rows [4];
        int g;
        int wi;
        rows = '{0, 1, 239, 240};
        resetn = 1'b0; vid_x = 12'd400; vid_y = 12'd300;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick();
        mon_en = 1'b1;
        tick(); tick();

        // Reset state
        resetn = 1'b1;
        exp_port(cyc, 17'd0, 1'b1, 1'b0, "reset_port");
        @(negedge clock25mhz);
        chk("reset_ack", 32'(cpu_ack), 32'd0);
        chk("reset_rdata", 32'(cpu_rdata), 32'd0);
        chk("reset_rgb", 32'({vid_r, vid_g, vid_b}), 32'd0);
        tick();

        // Video fetch of (3,1) = 323 = E3
        vid_x = 12'd3; vid_y = 12'd1;
        exp_port(cyc, 17'd323, 1'b1, 1'b0, "fetch_323");
        exp_vid(cyc + 2, 24'hFF00FF, "pix_E3");
        tick(); tick(); tick();

        // Idle-cycle CPU write then read back
        exp_port(cyc, 17'd100, 1'b1, 1'b1, "wr100_grant");
        cpu_txn(1'b1, 17'd100, 8'h1C, 1'b0, 8'h00, 2, 2, "wr100");
        exp_port(cyc, 17'd100, 1'b1, 1'b0, "rd100_grant");
        cpu_txn(1'b0, 17'd100, 8'h00, 1'b1, 8'h1C, 2, 2, "rd100");

        // Out-of-range CPU write and read, then out-of-range video
        exp_port(cyc, 17'd76800, 1'b1, 1'b0, "oor_wr_grant");
        cpu_txn(1'b1, 17'd76800, 8'hAA, 1'b0, 8'h00, 2, 2, "oor_wr");
        exp_port(cyc, 17'd76800, 1'b1, 1'b0, "oor_rd_grant");
        cpu_txn(1'b0, 17'd76800, 8'h00, 1'b1, 8'h00, 2, 2, "oor_rd");
        vid_x = 12'd320;
        exp_port(cyc, 17'd76800, 1'b1, 1'b0, "oor_vid_noread");
        exp_vid(cyc + 2, 24'h0, "oor_vid_black");
        tick(); tick(); tick();

        // Conflict: x steps 4->5 in the same cycle the CPU asks
        vid_x = 12'd4;
        tick(); tick();
        vid_x = 12'd5;
        exp_port(cyc, 17'd325, 1'b1, 1'b0, "conf_video_first");
        exp_port(cyc + 1, 17'd323, 1'b1, 1'b0, "conf_cpu_second");
        cpu_txn(1'b0, 17'd323, 8'h00, 1'b1, 8'hE3, 3, 3, "conf_rd323");
        tick();

        // Reset pulse while the CPU read sits in WAIT
        vid_x = 12'd7; vid_y = 12'd2;
        tick(); tick();
        g = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd50;
        exp_port(g, 17'd50, 1'b1, 1'b0, "rst_rd_grant");
        tick();
        resetn = 1'b0; cpu_req = 1'b0;
        tick();
        resetn = 1'b1;
        exp_port(g + 2, 17'd647, 1'b1, 1'b0, "rst_refetch");
        @(negedge clock25mhz);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_rgb", 32'({vid_r, vid_g, vid_b}), 32'd0);
        for (int n = 0; n < 6; n++) tick();

        // Scan rows with each x held two cycles while a CPU writer keeps requesting
        wi = 0;
        fork
            begin
                for (int r = 0; r < 4; r++) begin
                    for (int x = 0; x < 330; x++) begin
                        vid_x = 12'(x); vid_y = 12'(rows[r]);
                        if (x < W && rows[r] < H)
                            exp_port(cyc, 17'(rows[r] * W + x), 1'b1, 1'b0, "scan_fetch");
                        tick(); tick();
                    end
                end
                vid_x = 12'd0; vid_y = 12'd0;
                exp_port(cyc, 17'd0, 1'b1, 1'b0, "wrap_fetch0");
                tick(); tick(); tick(); tick();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    cpu_txn(1'b1, 17'(70000 + wi), 8'(wi * 7 + 1), 1'b0, 8'h00, 2, 3,
                            "scan_cpu_wr");
                    wi++;
                end
            end
        join
        tick(); tick(); tick(); tick();

        chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
        chk("port_queue_drained", 32'(pq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: the video scanout and a CPU-side request port.
- Scanout is driven by the hdmi block's x/y coordinates and always has priority. The CPU port gets every RAM cycle scanout does not need.
- Stored pixels are RGB332, one byte per pixel, row-major. They are expanded to 8-bit r/g/b for the hdmi block.
- With the 2-cycle video latency below, the hdmi block is instantiated with CYCLE_DELAY=2.

Parameters:
- WIDTH, 320, framebuffer width in pixels.
- HEIGHT, 240, framebuffer height in pixels.
- ADDR_W, $clog2(WIDTH*HEIGHT) (17), RAM and CPU byte-address width.

Ports:
- clock25mhz  in  1  pixel/system clock
- resetn  in  1  reset
- vid_x  in  12  scanout column (from hdmi x)
- vid_y  in  12  scanout row (from hdmi y)
- vid_r  out  8  expanded red to hdmi
- vid_g  out  8  expanded green to hdmi
- vid_b  out  8  expanded blue to hdmi
- cpu_req  in  1  CPU request; held with cpu_we/addr/wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address (y*WIDTH + x)
- cpu_wdata  in  8  write pixel
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read pixel; valid with cpu_ack, held until the next read completes
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, 1-cycle registered latency

Interface: one clock, clock25mhz; reset resetn is synchronous and active-low.

Behaviour:
- **Reset values:** vid_r/g/b=0, cpu_ack=0, cpu_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0. FSM goes to IDLE. last_vid_addr is set to all-ones, so the first in-range coordinate always fetches.
- **Reset mid-transaction:** any pending CPU transaction is aborted with no ack. The requester must re-issue it.
- **Video address:** vaddr = vid_y*WIDTH + vid_x, combinational, constant multiply. A coordinate is in range iff vid_x<WIDTH and vid_y<HEIGHT.
- **Video fetch:** issued in cycle N when the coordinate is in range and vaddr != last_vid_addr.
  - Cycle N: mem_addr=vaddr, mem_we=0, and last_vid_addr<=vaddr.
  - Cycle N+1: mem_rdata is captured into pix_reg.
  - From N+2: vid_r/g/b reflect the new pixel. Total latency 2 cycles.
- **Out-of-range coordinate:** no fetch, and vid_r/g/b become 0 two cycles later. The same latency is kept through a valid-bit pipeline.
- **Pixel expansion:** r={p[7:5],p[7:5],p[7:6]}, g={p[4:2],p[4:2],p[4:3]}, b={p[1:0],p[1:0],p[1:0],p[1:0]}.
- **Port free:** mem_we=0 and mem_addr holds its last value when neither requester uses the port.
- **CPU FSM:**
  - IDLE: if cpu_req and no video fetch this cycle, grant. Drive mem_addr=cpu_addr, mem_we=cpu_we&in_range, mem_wdata=cpu_wdata, then go to WAIT. Otherwise stay in IDLE.
  - WAIT: capture mem_rdata into cpu_rdata if the op is a read. Capture 0 if the read address is out of range. The RAM port is free for video this cycle. Go to ACK.
  - ACK: cpu_ack=1 for exactly one cycle, then IDLE. cpu_req is ignored in ACK, so a requester that drops req on the cycle after ack never double-issues.
- **Grant-to-ack latency:** 2 cycles. Total latency = 2 + cycles lost to video priority.
- **CPU address out of range** (cpu_addr >= WIDTH*HEIGHT): the write is dropped with mem_we=0, a read returns 0, and the transaction is still acked.
- **Simultaneous video fetch and CPU request:** video wins and the CPU stays in IDLE. Because x changes every 2 clocks, the CPU waits at most 1 cycle per pixel.
- **Wrap:** the vid_x/vid_y wrap to 0,0 causes a fetch at address 0. No special casing.
- **Back-to-back same coordinate:** no refetch. A CPU write to the pixel currently on screen is not visible until that coordinate is next fetched.

Decomposition:
- Shared package fb_pkg holds:
  - FB_WIDTH and FB_HEIGHT constants.
  - The CPU FSM state enum {IDLE, WAIT, ACK}.
  - An rgb332_expand function, reused by any future sprite or overlay block.
- One natural sub-module: fb_cpu_port. It contains the CPU FSM, the rdata capture and the ack pulse, and takes a grant-allowed input from the video side.
- Everything else lives in fb_arbiter.

Test Plan:
- **Video fetch:** after reset, drive vid_x=3, vid_y=1 with mem model byte[323]=8'hE3. Expect mem_addr=323 and mem_we=0 in that cycle; two cycles later vid_r=8'hFF, vid_g=8'h00, vid_b=8'hFF.
- **Idle-cycle CPU write:** cpu_req=1, cpu_we=1, cpu_addr=100, cpu_wdata=8'h1C, with vid_x held constant. Expect mem_we=1 and mem_addr=100 in the grant cycle, then cpu_ack exactly 2 cycles later for one cycle. A following read of 100 returns cpu_rdata=8'h1C with its ack.
- **Conflict:** cpu_req rises in the same cycle vid_x steps 4->5. Expect the video fetch of y*320+5 first, the CPU grant one cycle later, and ack 3 cycles after req.
- **Out-of-range accesses:** cpu_addr=76800 with a write. Expect no mem_we, and ack after 2 cycles. Then vid_x=320 gives vid_r/g/b=0 two cycles later with no RAM read.
- **Reset mid-transaction:** pulse resetn low for 1 cycle in the WAIT state. Expect no cpu_ack, all outputs zero, and the first new coordinate refetched even if it equals the pre-reset one.
- **Full-frame scan:** sweep the hdmi-style x/y scan (each x held 2 cycles) while a CPU writer spams req. Expect every pixel to match the mem model at 2-cycle latency, and every CPU request acked within 3 cycles.
